// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
// Define AES_ENC_ROUNDKEY_OUT_EN to expose round key 10 on last_round_key.
module aes128_encrypt_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
`ifdef AES_ENC_ROUNDKEY_OUT_EN
  ,
  output logic [127:0] last_round_key
`endif
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_reg, rk_reg, rk_next, sb_sr, round_out;
  logic [3:0]   round;
  logic         accept;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte (row r, column c) lives at bits [127-8*(4c+r) -: 8]
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127-8*(4*c+row) -: 8] = sbox(s[127-8*(4*((c+row)%4)+row) -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rc, 24'h0};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64]  ^ n0;
    n2 = rk[63:32]  ^ n1;
    n3 = rk[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign sb_sr     = sub_shift(state_reg);
  assign rk_next   = key_expand(rk_reg, rcon(round));
  assign round_out = ((round == 4'd10) ? sb_sr : mix_columns(sb_sr)) ^ rk_next;

  always_ff @(posedge clk) begin
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  // in_ready is gated by rst so nothing is offered while reset is held
  always_comb begin
    fsm_d     = fsm_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          accept = 1'b1;
          fsm_d  = ROUND;
        end
      end
      ROUND: begin
        busy = 1'b1;
        if (round == 4'd10) fsm_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= '0;
      rk_reg     <= '0;
      round      <= '0;
      ciphertext <= '0;
`ifdef AES_ENC_ROUNDKEY_OUT_EN
      last_round_key <= '0;
`endif
    end else begin
      case (fsm_q)
        IDLE: begin
          round <= '0;
          if (accept) begin
            state_reg <= plaintext ^ key;
            rk_reg    <= key;
            round     <= 4'd1;
          end
        end
        ROUND: begin
          state_reg <= round_out;
          rk_reg    <= rk_next;
          if (round == 4'd10) begin
            ciphertext <= round_out;
            round      <= '0;
`ifdef AES_ENC_ROUNDKEY_OUT_EN
            last_round_key <= rk_next;
`endif
          end else begin
            round <= round + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Self-checking bench for aes128_encrypt_iter: FIPS-197 vectors, a byte-level reference
// model for random vectors, and handshake/reset corner cases.
module tb_aes128_encrypt_iter;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready;
  logic [127:0] plaintext, key;
  logic         in_ready, out_valid, busy;
  logic [127:0] ciphertext, last_round_key;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] sb[256];

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    logic [127:0] lrk;
  } vec_t;

  vec_t tbl[2];

  always #5 clk = ~clk;

  aes128_encrypt_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .ciphertext(ciphertext), .busy(busy)
`ifdef AES_ENC_ROUNDKEY_OUT_EN
    , .last_round_key(last_round_key)
`endif
  );

`ifdef AES_ENC_ROUNDKEY_OUT_EN
`else
  assign last_round_key = '0;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, cyc=%0d required < 20000", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic void aes_model(input logic [127:0] pt, input logic [127:0] k,
                                    output logic [127:0] ct, output logic [127:0] lrk);
    logic [31:0] w[44];
    logic [31:0] temp;
    logic [7:0]  s[16];
    logic [7:0]  t[16];
    logic [7:0]  rc, a0, a1, a2, a3;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sb[temp[31:24]], sb[temp[23:16]], sb[temp[15:8]], sb[temp[7:0]]};
        temp = temp ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*c+row] = sb[s[4*((c+row)%4)+row]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
          s[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) ct[127-8*j -: 8] = s[j];
    lrk = {w[40], w[41], w[42], w[43]};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_vec(input logic [127:0] k, input logic [127:0] p, input logic [127:0] ect,
                         input logic [127:0] elrk, input string tag);
    int g, lat;
    in_valid = 1'b1; key = k; plaintext = p;
    g = 0;
    while (!in_ready && g < 40) begin
      tick();
      g++;
    end
    tick();
    in_valid = 1'b0; key = rnd128(); plaintext = rnd128();
    check({tag, " busy_after_accept"}, 128'(busy), 128'd1);
    wait_out(lat);
    check({tag, " latency"}, 128'(lat), 128'd10);
    check({tag, " ciphertext"}, ciphertext, ect);
`ifdef AES_ENC_ROUNDKEY_OUT_EN
    check({tag, " last_round_key"}, last_round_key, elrk);
`endif
    tick();
    check({tag, " out_valid_drop"}, 128'(out_valid), 128'd0);
  endtask

  initial begin
    logic [127:0] k, p, ect, elrk, k2, p2, ect2, elrk2;
    int lat, nv, t0, t1;
    logic acc_now;
    logic [127:0] got[$];

    tbl[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    tbl[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
               128'h3925841d02dc09fbdc118597196a0b32, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    build_sbox();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; plaintext = '0; key = '0;
    tick(); tick(); tick();
    check("reset in_ready", 128'(in_ready), 128'd0);
    check("reset out_valid", 128'(out_valid), 128'd0);
    check("reset busy", 128'(busy), 128'd0);
    check("reset ciphertext", ciphertext, 128'd0);
    check("reset last_round_key", last_round_key, 128'd0);
    rst = 1'b0;
    tick();
    check("idle in_ready", 128'(in_ready), 128'd1);
    check("idle busy", 128'(busy), 128'd0);

    for (int i = 0; i < 2; i++) run_vec(tbl[i].key, tbl[i].pt, tbl[i].ct, tbl[i].lrk, "fips");

    for (int i = 0; i < 4; i++) begin
      k = rnd128(); p = rnd128();
      aes_model(p, k, ect, elrk);
      run_vec(k, p, ect, elrk, "random");
    end

    // Backpressure: result held 20 cycles with out_ready low, in_valid ignored
    out_ready = 1'b0; in_valid = 1'b1; key = tbl[1].key; plaintext = tbl[1].pt;
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    check("bp latency", 128'(lat), 128'd10);
    in_valid = 1'b1; key = rnd128(); plaintext = rnd128();
    for (int i = 0; i < 20; i++) begin
      check("bp ciphertext_hold", ciphertext, tbl[1].ct);
      check("bp valid_ready", 128'({out_valid, in_ready}), 128'(2'b10));
`ifdef AES_ENC_ROUNDKEY_OUT_EN
      check("bp last_round_key_hold", last_round_key, tbl[1].lrk);
`endif
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp release out_valid", 128'(out_valid), 128'd0);
    check("bp release in_ready", 128'(in_ready), 128'd1);

    // Inputs churn during ROUND; result must still match the accepted vector
    k = rnd128(); p = rnd128();
    aes_model(p, k, ect, elrk);
    in_valid = 1'b1; key = k; plaintext = p;
    tick();
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_valid = 1'($urandom_range(0, 1)); key = rnd128(); plaintext = rnd128();
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check("churn latency", 128'(lat), 128'd10);
    check("churn ciphertext", ciphertext, ect);
    tick();
    check("churn out_valid_drop", 128'(out_valid), 128'd0);

    // Reset during round 5 aborts the block
    k = rnd128(); p = rnd128();
    in_valid = 1'b1; key = k; plaintext = p;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    check("abort busy_before", 128'(busy), 128'd1);
    rst = 1'b1;
    tick();
    check("abort out_valid", 128'(out_valid), 128'd0);
    check("abort busy", 128'(busy), 128'd0);
    check("abort in_ready", 128'(in_ready), 128'd0);
    check("abort ciphertext", ciphertext, 128'd0);
    check("abort last_round_key", last_round_key, 128'd0);
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) nv++;
      tick();
    end
    check("abort no_out_valid", 128'(nv), 128'd0);
    k = rnd128(); p = rnd128();
    aes_model(p, k, ect, elrk);
    run_vec(k, p, ect, elrk, "post_reset");

    // Back-to-back with in_valid held high
    k = rnd128(); p = rnd128(); k2 = rnd128(); p2 = rnd128();
    aes_model(p, k, ect, elrk);
    aes_model(p2, k2, ect2, elrk2);
    out_ready = 1'b1; in_valid = 1'b1; key = k; plaintext = p;
    t0 = -1; t1 = -1;
    for (int i = 0; i < 40; i++) begin
      acc_now = in_valid && in_ready;
      tick();
      if (acc_now) begin
        if (t0 < 0) begin
          t0 = cyc; key = k2; plaintext = p2;
        end else begin
          t1 = cyc; in_valid = 1'b0;
        end
      end
      if (out_valid) got.push_back(ciphertext);
    end
    in_valid = 1'b0;
    check("b2b accept_spacing", 128'(t1 - t0), 128'd12);
    check("b2b result_count", 128'(got.size()), 128'd2);
    check("b2b first_ct", (got.size() > 0) ? got[0] : 128'd0, ect);
    check("b2b second_ct", (got.size() > 1) ? got[1] : 128'd0, ect2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes128_encrypt_iter.md
# aes128_encrypt_iter

Iterative AES-128 encryption core, one cipher round per clock, with round keys expanded on the fly from the cipher key. It is the forward-direction counterpart of the decryption datapath. It produces the ciphertext, and optionally the final round key, that the decryption side consumes. It sits between the plaintext source and any downstream block through a valid/ready handshake on each side.

## Interface
Parameters: none (AES-128 fixed: 128-bit block, 128-bit key, 10 rounds).

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  plaintext/key pair offered
- in_ready  output  1  core can accept a block
- plaintext  input  128  block; bits [127:120] = state byte s(0,0), column-major per FIPS-197
- key  input  128  cipher key, same byte order
- out_valid  output  1  ciphertext available
- out_ready  input  1  downstream accepts ciphertext
- ciphertext  output  128  result, same byte order
- busy  output  1  high in ROUND state
- last_round_key  output  128  round key 10; present only with AES_ENC_ROUNDKEY_OUT_EN

## Operation
- FSM states:
  - IDLE (in_ready=1)
  - ROUND (busy=1)
  - DONE (out_valid=1)
- IDLE, in_valid=1: accept; state_reg <= plaintext ^ key; rk_reg <= key; round <= 1; go to ROUND.
- ROUND, each cycle:
  - rk_next = expand(rk_reg, rcon[round]); rcon = 01,02,04,08,10,20,40,80,1B,36.
  - Rounds 1-9: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ rk_next.
  - Round 10: MixColumns skipped.
  - rk_reg <= rk_next; round increments.
  - After round 10: ciphertext <= result; go to DONE.
- expand() applies RotWord, SubWord and Rcon to word 3, then chains the XOR across w0..w3.
- SubBytes uses 16 forward S-box instances for state plus 4 for key expansion, all combinational.
- DONE: ciphertext and out_valid held stable until out_ready=1. Then return to IDLE on the next edge.
- in_valid is ignored outside IDLE. Plaintext and key are sampled only at the accept edge and may change afterwards.
- round is a 4-bit counter, range 1..10. It never wraps during operation and is cleared to 0 in IDLE.

## Timing
- Accept at edge E0. Rounds 1..10 are registered at edges E1..E10. out_valid rises after E10, so it is first high in the cycle following E10.
- Latency from accept edge to out_valid: 10 cycles. With out_ready held high, throughput is one block per 12 cycles.
- DONE to IDLE needs 1 cycle. No accept occurs in the cycle out_valid drops; the next accept is possible one cycle after the handshake.
- Reset values:
  - state IDLE
  - in_ready=1 (from the cycle after rst deasserts; 0 while rst is high)
  - out_valid=0, busy=0
  - ciphertext=0, last_round_key=0
  - internal state_reg, rk_reg and round all cleared to 0
- Reset mid-operation (ROUND or DONE) aborts the block. The pending ciphertext is discarded and no out_valid pulse is produced.
- rst has priority over every handshake in the same cycle.

## Configuration
- AES_ENC_ROUNDKEY_OUT_EN defined:
  - last_round_key port exists.
  - It is loaded with rk_next of round 10 at the same edge as ciphertext.
  - It is valid exactly when out_valid=1 and is held with ciphertext.
  - The decryption side uses it as the starting key for the inverse key schedule.
- Undefined: port and register are absent; behaviour is otherwise identical.

## Test plan
- Reset, then FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a. out_valid is first high 10 cycles after the accept edge.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32. With the macro, last_round_key = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure: out_ready held 0 for 20 cycles after out_valid -> ciphertext stable, in_ready=0 throughout. When out_ready=1, out_valid drops the next cycle.
- in_valid toggled and plaintext/key changed during ROUND -> no new accept, and the result still equals the originally accepted vector.
- rst asserted at round 5 -> all outputs 0 next cycle, no out_valid. A vector applied after reset produces the correct ciphertext.
- Back-to-back: two vectors with in_valid held high and out_ready=1 -> both ciphertexts correct, accept edges 12 cycles apart.
